// File: rtl/scancode_pkg.sv
// Shared constants and types for the PS/2 set-2 to SAM keyboard matrix decoder.
// Prefix bytes, decoder states and hotkey ids live here so keymaps can be swapped freely.
package scancode_pkg;

    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_REL      = 8'hF0;
    localparam logic [7:0] SC_PAUSE    = 8'hE1;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] SC_ERR0     = 8'h00;
    localparam logic [7:0] SC_ERRF     = 8'hFF;

    // Bytes that follow E1 in the Pause make sequence
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_REL,
        ST_EXTREL,
        ST_SKIP
    } scan_state_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_DEL_EXT,
        SP_F5,
        SP_BKSP
    } special_e;

    // Self-test result or keyboard error: the keyboard's own state is unknown afterwards
    function automatic logic is_clear_code(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_BAT_FAIL) || (b == SC_ERR0) || (b == SC_ERRF);
    endfunction

endpackage

// File: rtl/sam_keymap.sv
// SAM Coupe layout: maps {ext, set-2 scancode} to a matrix position and hotkey id.
// Purely combinational; a different machine layout replaces only this file.
module sam_keymap
    import scancode_pkg::*;
(
    input  logic [8:0] code,
    output logic       hit,
    output logic [3:0] row,
    output logic [2:0] col,
    output special_e   special
);

    function automatic logic [7:0] rc(input int r, input int c);
        return {1'b1, r[3:0], c[2:0]};
    endfunction

    logic [7:0] m;

    always_comb begin
        m       = 8'h00;
        special = SP_NONE;
        case (code)
            // row 0: shift Z X C V F1 F2 F3 (both shifts share the one bit)
            9'h012: m = rc(0, 0);
            9'h059: m = rc(0, 0);
            9'h01A: m = rc(0, 1);
            9'h022: m = rc(0, 2);
            9'h021: m = rc(0, 3);
            9'h02A: m = rc(0, 4);
            9'h005: m = rc(0, 5);
            9'h006: m = rc(0, 6);
            9'h004: m = rc(0, 7);
            // row 1: A S D F G F4 (F5 is an NMI hotkey, not a matrix key) F6
            9'h01C: m = rc(1, 0);
            9'h01B: m = rc(1, 1);
            9'h023: m = rc(1, 2);
            9'h02B: m = rc(1, 3);
            9'h034: m = rc(1, 4);
            9'h00C: m = rc(1, 5);
            9'h003: special = SP_F5;
            9'h00B: m = rc(1, 7);
            // row 2: Q W E R T F7 F8 F9
            9'h015: m = rc(2, 0);
            9'h01D: m = rc(2, 1);
            9'h024: m = rc(2, 2);
            9'h02D: m = rc(2, 3);
            9'h02C: m = rc(2, 4);
            9'h083: m = rc(2, 5);
            9'h00A: m = rc(2, 6);
            9'h001: m = rc(2, 7);
            // row 3: 1 2 3 4 5 Esc Tab Caps
            9'h016: m = rc(3, 0);
            9'h01E: m = rc(3, 1);
            9'h026: m = rc(3, 2);
            9'h025: m = rc(3, 3);
            9'h02E: m = rc(3, 4);
            9'h076: m = rc(3, 5);
            9'h00D: m = rc(3, 6);
            9'h058: m = rc(3, 7);
            // row 4: 0 9 8 7 6 - + Delete
            9'h045: m = rc(4, 0);
            9'h046: m = rc(4, 1);
            9'h03E: m = rc(4, 2);
            9'h03D: m = rc(4, 3);
            9'h036: m = rc(4, 4);
            9'h04E: m = rc(4, 5);
            9'h055: m = rc(4, 6);
            9'h066: begin m = rc(4, 7); special = SP_BKSP; end
            // row 5: P O I U Y = " F0
            9'h04D: m = rc(5, 0);
            9'h044: m = rc(5, 1);
            9'h043: m = rc(5, 2);
            9'h03C: m = rc(5, 3);
            9'h035: m = rc(5, 4);
            9'h054: m = rc(5, 5);
            9'h05B: m = rc(5, 6);
            9'h009: m = rc(5, 7);
            // row 6: Return L K J H ; : Edit
            9'h05A: m = rc(6, 0);
            9'h04B: m = rc(6, 1);
            9'h042: m = rc(6, 2);
            9'h03B: m = rc(6, 3);
            9'h033: m = rc(6, 4);
            9'h04C: m = rc(6, 5);
            9'h052: m = rc(6, 6);
            9'h170: m = rc(6, 7);
            // row 7: Space Symbol M N B , . Inv
            9'h029: m = rc(7, 0);
            9'h011: m = rc(7, 1);
            9'h111: m = rc(7, 1);
            9'h03A: m = rc(7, 2);
            9'h031: m = rc(7, 3);
            9'h032: m = rc(7, 4);
            9'h041: m = rc(7, 5);
            9'h049: m = rc(7, 6);
            9'h00E: m = rc(7, 7);
            // row 8: Ctrl and the cursor keys
            9'h014: m = rc(8, 0);
            9'h114: m = rc(8, 0);
            9'h175: m = rc(8, 1);
            9'h172: m = rc(8, 2);
            9'h16B: m = rc(8, 3);
            9'h174: m = rc(8, 4);
            // extended Delete only feeds the reset hotkey
            9'h171: special = SP_DEL_EXT;
            default: m = 8'h00;
        endcase
    end

    assign hit = m[7];
    assign row = m[6:3];
    assign col = m[2:0];

endmodule

// File: rtl/scancode_to_matrix_sync.sv
// Single-clock PS/2 set-2 decoder maintaining the SAM key matrix and hotkey reset pulses.
// Bytes arrive as one-cycle strobes; matrix, hotkey state and pulses are all registered.
module scancode_to_matrix_sync
    import scancode_pkg::*;
#(
    parameter int                   ROWS      = 9,
    parameter int                   COLS      = 8,
    parameter int                   PULSE_W   = 16,
    parameter logic [PULSE_W-1:0]   PULSE_LEN = 16'd50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_valid,
    input  logic [7:0]      scan,
    input  logic [ROWS-1:0] sam_row,
    output logic [COLS-1:0] sam_col,
    output logic            user_reset,
    output logic            master_reset,
    output logic            user_nmi,
    output logic            matrix_clear
);

    scan_state_e state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic        key_evt, key_make, clear_evt, ext_cur;

    logic        kb_hit;
    logic [3:0]  kb_row;
    logic [2:0]  kb_col;
    special_e    kb_special;

    logic [ROWS-1:0][COLS-1:0] matrix_q;
    logic        f5_q, del_ext_q;

    // The extension flag is a property of the prefix state, so lookup runs every cycle
    assign ext_cur = (state_q == ST_EXT) || (state_q == ST_EXTREL);

    sam_keymap u_keymap (
        .code    ({ext_cur, scan}),
        .hit     (kb_hit),
        .row     (kb_row),
        .col     (kb_col),
        .special (kb_special)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        key_evt   = 1'b0;
        key_make  = 1'b0;
        clear_evt = 1'b0;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_clear_code(scan)) begin
                        clear_evt = 1'b1;
                    end else if (scan == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (scan == SC_REL) begin
                        state_d = ST_REL;
                    end else if (scan == SC_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_SKIP;
                    end else begin
                        key_evt  = 1'b1;
                        key_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (scan == SC_REL) begin
                        state_d = ST_EXTREL;
                    end else begin
                        key_evt  = 1'b1;
                        key_make = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_REL, ST_EXTREL: begin
                    key_evt = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_q     <= '0;
            f5_q         <= 1'b0;
            del_ext_q    <= 1'b0;
            matrix_clear <= 1'b0;
        end else begin
            matrix_clear <= clear_evt;
            if (clear_evt) begin
                matrix_q  <= '0;
                f5_q      <= 1'b0;
                del_ext_q <= 1'b0;
            end else if (key_evt) begin
                // Extended 12/59 (Print Screen fake shifts) have no keymap entry and drop here
                if (kb_hit && (32'(kb_row) < ROWS) && (32'(kb_col) < COLS))
                    matrix_q[kb_row][kb_col] <= key_make;
                if (kb_special == SP_F5)      f5_q      <= key_make;
                if (kb_special == SP_DEL_EXT) del_ext_q <= key_make;
            end
        end
    end

    // Several rows may be selected; a pressed key in any of them pulls its column low
    always_comb begin
        sam_col = '1;
        for (int r = 0; r < ROWS; r++)
            if (!sam_row[r]) sam_col = sam_col & ~matrix_q[r];
    end

    logic       ctrl, alt, bksp;
    logic [2:0] combo, combo_q, pulse_n;

    assign ctrl  = matrix_q[8][0];
    assign alt   = matrix_q[7][1];
    assign bksp  = matrix_q[4][7];
    assign combo = {f5_q, ctrl & alt & bksp, ctrl & alt & del_ext_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) combo_q <= 3'b000;
        else        combo_q <= combo;
    end

    for (genvar i = 0; i < 3; i++) begin : g_pulse
        logic [PULSE_W-1:0] cnt;
        // Only a fresh press (re)loads; holding the combo lets the count run out
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                       cnt <= '0;
            else if (combo[i] && !combo_q[i]) cnt <= PULSE_LEN;
            else if (cnt != '0)               cnt <= cnt - 1'b1;
        end
        assign pulse_n[i] = (cnt == '0);
    end

    assign user_reset   = pulse_n[0];
    assign master_reset = pulse_n[1];
    assign user_nmi     = pulse_n[2];

endmodule

// File: tb/tb_scancode_to_matrix_sync.sv
// Bench for scancode_to_matrix_sync: directed key scenarios plus a random byte stream,
// checked every cycle against a key-state model kept in the bench.
module tb_scancode_to_matrix_sync;

    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_valid;
    logic [7:0] scan;
    logic [8:0] sam_row;
    logic [7:0] sam_col;
    logic       user_reset, master_reset, user_nmi, matrix_clear;

    int total = 0;
    int bad   = 0;

    scancode_to_matrix_sync #(.ROWS(9), .COLS(8), .PULSE_W(16), .PULSE_LEN(16'(L))) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_valid   (scan_valid),
        .scan         (scan),
        .sam_row      (sam_row),
        .sam_col      (sam_col),
        .user_reset   (user_reset),
        .master_reset (master_reset),
        .user_nmi     (user_nmi),
        .matrix_clear (matrix_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // kind: 0 = matrix key, 1 = F5 hotkey, 2 = extended Delete hotkey
    typedef struct {bit ext; logic [7:0] code; int kind; int row; int col;} kent_t;
    kent_t ktab[$];

    task automatic add(input bit e, input logic [7:0] c, input int k, input int r, input int co);
        kent_t t;
        t.ext = e; t.code = c; t.kind = k; t.row = r; t.col = co;
        ktab.push_back(t);
    endtask

    bit m_key [9][8];
    bit m_f5, m_del, m_ext, m_rel, m_clr;
    int m_skip;
    int m_cnt [3];
    bit m_prev [3];

    task automatic model_reset();
        foreach (m_key[r, c]) m_key[r][c] = 1'b0;
        m_f5 = 0; m_del = 0; m_ext = 0; m_rel = 0; m_clr = 0; m_skip = 0;
        for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_prev[i] = 0; end
    endtask

    task automatic apply(input bit e, input bit make, input logic [7:0] b);
        foreach (ktab[i]) begin
            if (ktab[i].ext == e && ktab[i].code == b) begin
                if (ktab[i].kind == 1)      m_f5 = make;
                else if (ktab[i].kind == 2) m_del = make;
                else                        m_key[ktab[i].row][ktab[i].col] = make;
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit idle;
        idle = !m_ext && !m_rel;
        if (m_skip > 0) begin
            m_skip--;
        end else if (idle && (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF)) begin
            foreach (m_key[r, c]) m_key[r][c] = 1'b0;
            m_f5 = 0; m_del = 0; m_clr = 1;
        end else if (idle && b == 8'hE0) begin
            m_ext = 1;
        end else if (idle && b == 8'hE1) begin
            m_skip = 7;
        end else if (!m_rel && b == 8'hF0) begin
            m_rel = 1;
        end else begin
            apply(m_ext, !m_rel, b);
            m_ext = 0; m_rel = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit combo [3];
            combo[0] = m_key[8][0] && m_key[7][1] && m_del;
            combo[1] = m_key[8][0] && m_key[7][1] && m_key[4][7];
            combo[2] = m_f5;
            for (int i = 0; i < 3; i++) begin
                if (combo[i] && !m_prev[i]) m_cnt[i] = L;
                else if (m_cnt[i] > 0)      m_cnt[i]--;
                m_prev[i] = combo[i];
            end
            m_clr = 0;
            if (scan_valid) model_byte(scan);
        end
    end

    function automatic logic [7:0] exp_col(input logic [8:0] rows);
        logic [7:0] v;
        v = 8'hFF;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 8; c++)
                if (!rows[r] && m_key[r][c]) v[c] = 1'b0;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_sam_col", {24'd0, sam_col}, {24'd0, exp_col(sam_row)});
            chk("model_user_reset", {31'd0, user_reset}, {31'd0, m_cnt[0] == 0});
            chk("model_master_reset", {31'd0, master_reset}, {31'd0, m_cnt[1] == 0});
            chk("model_user_nmi", {31'd0, user_nmi}, {31'd0, m_cnt[2] == 0});
            chk("model_matrix_clear", {31'd0, matrix_clear}, {31'd0, m_clr});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        scan_valid = 1'b1; scan = b;
        @(posedge clk); #1;
        scan_valid = 1'b0;
    endtask

    task automatic count_low(input string name);
        int low;
        low = 0;
        for (int i = 0; i < 4 * L; i++) begin
            @(negedge clk);
            if (!user_reset) low++;
        end
        chk(name, low, L);
        chk({name, "_end_high"}, {31'd0, user_reset}, 32'd1);
    endtask

    logic [7:0] pool [15] = '{8'h1C, 8'h1B, 8'h12, 8'h59, 8'h14, 8'h11, 8'h66, 8'h29,
                              8'h16, 8'h75, 8'h72, 8'h71, 8'h03, 8'h7E, 8'h77};
    logic [7:0] clr_codes [4] = '{8'hAA, 8'hFC, 8'h00, 8'hFF};

    initial begin
        add(0, 8'h1C, 0, 1, 0); add(0, 8'h1B, 0, 1, 1); add(0, 8'h12, 0, 0, 0);
        add(0, 8'h59, 0, 0, 0); add(0, 8'h14, 0, 8, 0); add(1, 8'h14, 0, 8, 0);
        add(0, 8'h11, 0, 7, 1); add(1, 8'h11, 0, 7, 1); add(0, 8'h66, 0, 4, 7);
        add(0, 8'h29, 0, 7, 0); add(0, 8'h16, 0, 3, 0); add(1, 8'h75, 0, 8, 1);
        add(1, 8'h72, 0, 8, 2); add(0, 8'h03, 1, 0, 0); add(1, 8'h71, 2, 0, 0);

        rst_n = 1'b0; scan_valid = 1'b0; scan = 8'h00; sam_row = 9'h000;
        #12;
        chk("reset_sam_col", {24'd0, sam_col}, 32'hFF);
        chk("reset_user_reset", {31'd0, user_reset}, 32'd1);
        chk("reset_master_reset", {31'd0, master_reset}, 32'd1);
        chk("reset_user_nmi", {31'd0, user_nmi}, 32'd1);
        chk("reset_matrix_clear", {31'd0, matrix_clear}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // press / release A
        send(8'h1C); sam_row = 9'h1FD;
        @(negedge clk); chk("press_A", {24'd0, sam_col}, 32'hFE);
        send(8'hF0); send(8'h1C);
        @(negedge clk); chk("release_A", {24'd0, sam_col}, 32'hFF);

        // extended Up, release, then keypad 8 does nothing
        send(8'hE0); send(8'h75); sam_row = 9'h0FF;
        @(negedge clk); chk("press_up", {24'd0, sam_col}, 32'hFD);
        send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk); chk("release_up", {24'd0, sam_col}, 32'hFF);
        send(8'h75);
        @(negedge clk); chk("keypad8_ignored", {24'd0, sam_col}, 32'hFF);

        // Pause sequence is skipped entirely
        sam_row = 9'h000;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        @(negedge clk); chk("pause_no_change", {24'd0, sam_col}, 32'hFF);
        send(8'h1C); sam_row = 9'h1FD;
        @(negedge clk); chk("after_pause_A", {24'd0, sam_col}, 32'hFE);
        sam_row = 9'h0FF;
        @(negedge clk); chk("pause_no_ctrl", {24'd0, sam_col}, 32'hFF);
        send(8'hF0); send(8'h1C);

        // Ctrl+Alt+Del: one pulse while held, a second after re-press
        send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
        count_low("cad_pulse1");
        send(8'hE0); send(8'hF0); send(8'h71);
        send(8'hE0); send(8'h71);
        count_low("cad_pulse2");
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h11);
        send(8'hE0); send(8'hF0); send(8'h71);

        // self-test clear
        send(8'h1C); send(8'h14); send(8'hAA); sam_row = 9'h000;
        @(negedge clk);
        chk("bat_clear_strobe", {31'd0, matrix_clear}, 32'd1);
        chk("bat_cleared", {24'd0, sam_col}, 32'hFF);
        @(negedge clk); chk("bat_strobe_one_cycle", {31'd0, matrix_clear}, 32'd0);
        send(8'h1C); sam_row = 9'h1FD;
        @(negedge clk); chk("bat_then_A", {24'd0, sam_col}, 32'hFE);
        send(8'hF0); send(8'h1C);

        // reset in the middle of a pulse and a prefix
        send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
        repeat (5) @(negedge clk);
        chk("pulse_running", {31'd0, user_reset}, 32'd0);
        send(8'hE0);
        rst_n = 1'b0; #1;
        chk("async_reset_pulse", {31'd0, user_reset}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        send(8'h75); sam_row = 9'h0FF;
        @(negedge clk); chk("reset_drops_prefix", {24'd0, sam_col}, 32'hFF);
        sam_row = 9'h000;
        @(negedge clk); chk("reset_clears_matrix", {24'd0, sam_col}, 32'hFF);

        // random byte stream
        for (int n = 0; n < 4000; n++) begin
            int p;
            @(posedge clk); #1;
            sam_row    = 9'($urandom);
            scan_valid = 1'($urandom);
            p = $urandom_range(0, 99);
            if (p < 15)      scan = 8'hE0;
            else if (p < 30) scan = 8'hF0;
            else if (p < 32) scan = 8'hE1;
            else if (p < 34) scan = clr_codes[$urandom_range(0, 3)];
            else             scan = pool[$urandom_range(0, 14)];
        end
        @(posedge clk); #1; scan_valid = 1'b0;
        repeat (3 * L) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scancode_to_matrix_sync.md
Name: scancode_to_matrix_sync

Overview:
- Clocked, parametrised PS/2 set-2 scancode decoder that maintains a ROWS x COLS key matrix for the SAM keyboard port.
- Successor to the strobe-clocked decoder:
  - single system clock with strobe input;
  - explicit prefix state machine, including the E1 Pause sequence skip;
  - fake-shift filtering;
  - matrix clear on keyboard self-test or error;
  - hotkey outputs as timed pulses.
- Sits between the PS/2 receiver and the ASIC keyboard read path.

Parameters:
- ROWS, 9, number of matrix rows (address lines, active-low select).
- COLS, 8, number of matrix columns returned.
- PULSE_LEN, 16'd50000, length in clk cycles of each hotkey output pulse.
- PULSE_W, 16, width of the pulse counter; PULSE_LEN must be < 2^PULSE_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_valid  in  1  one-cycle strobe: scan holds a new byte.
- scan  in  8  received scancode byte.
- sam_row  in  ROWS  row select, active low; multiple rows may be low at once.
- sam_col  out  COLS  column data, active low: bit is 0 if any selected row has that key pressed.
- user_reset  out  1  active-low pulse on Ctrl+Alt+Del.
- master_reset  out  1  active-low pulse on Ctrl+Alt+Backspace.
- user_nmi  out  1  active-low pulse on F5.
- matrix_clear  out  1  one-cycle high strobe whenever the matrix is forcibly cleared (debug/status).

Behaviour:
- Reset (async, rst_n=0):
  - all matrix bits 0 (released); sam_col = all ones;
  - FSM = IDLE, skip counter 0;
  - user_reset = master_reset = user_nmi = 1;
  - pulse counters 0; matrix_clear = 0.
- Only bytes with scan_valid=1 are consumed; one byte per strobe; back-to-back strobes are legal.
- FSM states: IDLE, EXT (after E0), REL (after F0), EXTREL (after E0 F0), SKIP (Pause).
  - IDLE: E0 -> EXT; F0 -> REL; E1 -> SKIP with counter = 7; other byte -> make code, non-extended.
  - EXT: F0 -> EXTREL; other -> make code, extended.
  - REL: byte -> break code, non-extended.
  - EXTREL: byte -> break code, extended.
  - SKIP: decrement counter per byte; at 0 -> IDLE. No matrix change while in SKIP.
  - After any make/break -> IDLE.
- Lookup: {ext, scan} goes to the keymap, which returns hit, row index, col index, and special id (NONE, DEL_EXT, F5, BKSP).
  - Make sets matrix[row][col] = 1; break clears it. Update is registered one cycle after the final byte's strobe.
  - sam_col is combinational from registered matrix and sam_row.
- Fake shift: extended 12 and extended 59 (Print Screen wrappers) are ignored.
- Non-extended 12 and 59 both map to row0 col0 (Caps Shift).
  - Releasing one shift while the other is held clears the bit. Accepted limitation; no per-key counting.
- Clear events: byte AA, FC, 00 or FF received in IDLE.
  - All matrix bits 0, F5/Ctrl/Alt state cleared, FSM IDLE, matrix_clear=1 for one cycle.
  - Pulses already running continue.
- Hotkeys evaluate on registered state:
  - combo_user = ctrl && alt && del_ext;
  - combo_master = ctrl && alt && bksp;
  - combo_nmi = f5 held.
  - Ctrl = row8 col0; Alt = row7 col1; Backspace = row4 col7; extended 71 is tracked separately as del_ext; F5 (03) is tracked separately.
- Pulse rule, per output:
  - Rising edge of combo loads counter = PULSE_LEN; output = 0 while counter != 0; counter decrements each cycle.
  - Holding the combo does not extend or retrigger; a combo that is released and re-pressed while the counter is non-zero restarts it.
  - PULSE_LEN = 0: output never asserts.
- Simultaneous scan_valid and a clear byte: the clear takes priority over lookup.
- Unmapped codes: no matrix change, FSM returns to IDLE.

Decomposition:
- Package scancode_pkg holds:
  - prefix constants: SC_EXT=E0, SC_REL=F0, SC_PAUSE=E1, SC_BAT_OK=AA, SC_BAT_FAIL=FC, SC_ERR0=00, SC_ERRF=FF;
  - FSM state enum;
  - special-key id enum;
  - PAUSE_SKIP=7.
- Sub-module sam_keymap: purely combinational.
  - Input: {ext, scan}. Outputs: hit, row[3:0], col[2:0], special.
  - Contains the full SAM layout table, so other machine layouts can swap the sub-module.

Test Plan:
- Press A: strobe 1C; sam_row=9'h1FD -> sam_col=8'hFE one cycle after strobe. Send F0 1C -> sam_col=8'hFF.
- Extended Up: strobe E0 75; sam_row=9'h0FF -> sam_col=8'hFD. Send E0 F0 75 -> 8'hFF. Plain 75 (keypad 8) -> no change.
- Pause then key: send E1 14 77 E1 F0 14 F0 77, then 1C -> matrix unchanged through the sequence; row1 col0 set after 1C; Ctrl bit never set.
- Ctrl+Alt+Del: 14, 11, E0 71 -> user_reset low for exactly PULSE_LEN cycles, then high while the keys are still held. Release E0 F0 71 and re-press -> second pulse. master_reset and user_nmi stay 1 throughout.
- Self-test clear: hold 1C and 14, send AA -> matrix_clear=1 for one cycle; all sam_col=FF for sam_row=0; FSM accepts 1C next.
- Reset mid-sequence: send E0, assert rst_n=0 mid-pulse -> user_reset=1 immediately. After release, byte 75 is decoded non-extended (no row8 change).
